// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the FSM state enum, req_size encodings, the word-align mask and
// the captured-request payload struct.
// Optional build macro used by the unit: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [XLEN-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  // Request fields kept after acceptance; the word address lives in mem_addr.
  typedef struct packed {
    logic            write;
    logic [1:0]      size;
    logic            sign_ext;
    logic [1:0]      offset;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Half needs addr[0]=0, word needs addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    return ((size == SZ_HALF) && offset[0]) ||
           ((size == SZ_WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational big-endian lane logic for the load/store unit.
// Ports:
//   size, sign_ext, offset : captured request attributes
//   rdata                  : word read from memory
//   wdata                  : right-justified store data
//   load_data_c            : extracted and sign/zero-extended load value
//   merge_data_c           : rdata with the addressed lanes replaced by wdata
// Offset 0 is bits [31:24]; half lanes use offset[1] only.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            sign_ext,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data_c,
  output logic [XLEN-1:0] merge_data_c
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane select for loads.
  always_comb begin
    sel_byte = rdata[31:24];
    case (offset)
      2'd0:    sel_byte = rdata[31:24];
      2'd1:    sel_byte = rdata[23:16];
      2'd2:    sel_byte = rdata[15:8];
      default: sel_byte = rdata[7:0];
    endcase
    sel_half = offset[1] ? rdata[15:0] : rdata[31:16];
  end

  // Extend loads and merge sub-word stores into the read word.
  always_comb begin
    load_data_c  = rdata;
    merge_data_c = wdata;
    case (size)
      SZ_BYTE: begin
        load_data_c  = {{24{sign_ext & sel_byte[7]}}, sel_byte};
        merge_data_c = rdata;
        case (offset)
          2'd0:    merge_data_c[31:24] = wdata[7:0];
          2'd1:    merge_data_c[23:16] = wdata[7:0];
          2'd2:    merge_data_c[15:8]  = wdata[7:0];
          default: merge_data_c[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        load_data_c  = {{16{sign_ext & sel_half[15]}}, sel_half};
        merge_data_c = rdata;
        if (offset[1]) merge_data_c[15:0]  = wdata[15:0];
        else           merge_data_c[31:16] = wdata[15:0];
      end
      default: begin
        load_data_c  = rdata;
        merge_data_c = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a datapath request port and a word-wide,
// big-endian data memory. Sub-word stores are read-modify-written.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   req_valid/req_ready             : request handshake (ready only when idle)
//   req_write, req_size, req_signed : store flag, size code, load extension
//   req_addr, req_wdata             : byte address, right-justified store data
//   resp_valid, resp_rdata, resp_err: one-cycle completion pulse and result
//   MemRead, MemWrite               : memory strobes (never both high)
//   mem_addr, Write_data            : word-aligned address, full store word
//   MemData_out                     : combinational memory read data
// Build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned half/word
// requests complete immediately with resp_err and no memory access.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            MemRead,
  output logic            MemWrite,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] Write_data,
  input  logic [XLEN-1:0] MemData_out
);

  lsu_state_e      state;
  lsu_req_t        cur;
  logic            bad_req_c;
  logic [XLEN-1:0] load_data_c;
  logic [XLEN-1:0] merge_data_c;

  // Requests rejected without touching memory.
`ifdef LSU_MISALIGN_TRAP_EN
  assign bad_req_c = (req_size == SZ_RSVD) || is_misaligned(req_size, req_addr[1:0]);
`else
  assign bad_req_c = (req_size == SZ_RSVD);
`endif

  lsu_lane_align u_lane_align (
    .size         (cur.size),
    .sign_ext     (cur.sign_ext),
    .offset       (cur.offset),
    .rdata        (MemData_out),
    .wdata        (cur.wdata),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  // Request FSM; every output is a register loaded on the state transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cur        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      mem_addr   <= '0;
      Write_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cur.write    <= req_write;
            cur.size     <= req_size;
            cur.sign_ext <= req_signed;
            cur.offset   <= req_addr[1:0];
            cur.wdata    <= req_wdata;
            req_ready    <= 1'b0;
            if (bad_req_c) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write && (req_size == SZ_WORD)) begin
              state      <= ST_WRITE;
              MemWrite   <= 1'b1;
              mem_addr   <= req_addr & WORD_ALIGN_MASK;
              Write_data <= req_wdata;
            end else begin
              // Loads and sub-word stores both start with a read.
              state    <= ST_READ;
              MemRead  <= 1'b1;
              mem_addr <= req_addr & WORD_ALIGN_MASK;
            end
          end
        end
        ST_READ: begin
          MemRead <= 1'b0;
          if (cur.write) begin
            state      <= ST_WRITE;
            MemWrite   <= 1'b1;
            Write_data <= merge_data_c;
          end else begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data_c;
          end
        end
        ST_WRITE: begin
          MemWrite   <= 1'b0;
          state      <= ST_RESP;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
